// File: rtl/keypad_scan_ctrl_if.sv
// Key FIFO drain handshake plus the sticky overflow status/clear pair.
// master = keypad_scan_ctrl, slave = consumer (display/UART/MCU glue).
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       ovf_clr;
  logic       overflow;

  modport master (output key_valid, key_code, overflow, input  key_ready, ovf_clr);
  modport slave  (input  key_valid, key_code, overflow, output key_ready, ovf_clr);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row rotation, press/release debounce, key FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         col,
  output logic [3:0]         row,
  keypad_scan_ctrl_if.master kif
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    col_lat_q, col_lat_d;
  logic          emit_push, rep_push, push;
  logic [3:0]    push_code;

  function automatic logic [1:0] low_idx(input logic [3:0] c);
    if (c[0])      return 2'd0;
    else if (c[1]) return 2'd1;
    else if (c[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // cnt_q is shared: press stability count in DEBOUNCE, release count in HOLD
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    cnt_d      = cnt_q;
    row_idx_d  = row_idx_q;
    col_lat_d  = col_lat_q;
    emit_push  = 1'b0;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          if (col == 4'b0000) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            col_lat_d = col;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (col != col_lat_q) begin
          state_d   = SCAN;
          row_idx_d = row_idx_q + 2'd1;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      EMIT: begin
        emit_push = 1'b1;
        cnt_d     = '0;
        state_d   = HOLD;
      end
      HOLD: begin
        if (col != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d     = '0;
          state_d   = SCAN;
          row_idx_d = row_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      scan_cnt_q <= '0;
      cnt_q      <= '0;
      row_idx_q  <= '0;
      col_lat_q  <= '0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      cnt_q      <= cnt_d;
      row_idx_q  <= row_idx_d;
      col_lat_q  <= col_lat_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_nxt;
  logic          rep_arm_q, rep_arm_d, rep_first_q, rep_first_d;

  // Once the held pattern changes, repeats stay disarmed until the next EMIT.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_arm_d   = rep_arm_q;
    rep_first_d = rep_first_q;
    rep_push    = 1'b0;
    rep_nxt     = rep_cnt_q + RW'(1);
    if (state_q == EMIT) begin
      rep_cnt_d   = '0;
      rep_arm_d   = 1'b1;
      rep_first_d = 1'b0;
    end else if (state_q == HOLD) begin
      if (rep_arm_q && col == col_lat_q) begin
        if (rep_nxt == (rep_first_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
          rep_push    = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
        end else begin
          rep_cnt_d = rep_nxt;
        end
      end else begin
        rep_cnt_d = '0;
        rep_arm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_arm_q   <= 1'b0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_arm_q   <= rep_arm_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_push = 1'b0;
`endif

  assign push      = emit_push | rep_push;
  assign push_code = {row_idx_q, low_idx(col_lat_q)};

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, full, empty, pop, wr_en, drop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && kif.key_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)             ovf_q <= 1'b1;
      else if (kif.ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign row           = 4'b0001 << row_idx_q;
  assign kif.key_valid = !empty;
  assign kif.key_code  = mem_q[rd_ptr_q];
  assign kif.overflow  = ovf_q;

endmodule
